// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame packetizer.
// The frame length depends on the UART_PACKETIZER_SEQ_EN build option.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SEQ,
    DATA,
    CSUM,
    GAP
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Bytes per frame: sync, optional sequence byte, data bytes, checksum.
  function automatic int frame_len(input int num_bytes);
`ifdef UART_PACKETIZER_SEQ_EN
    return num_bytes + 3;
`else
    return num_bytes + 2;
`endif
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Parameterized synchronous word FIFO with async active-low reset.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_packetizer.sv
// Buffers words and serializes each into a sync/data/checksum byte frame for a UART.
// Build option UART_PACKETIZER_SEQ_EN inserts a counted sequence byte after the sync byte.
module uart_packetizer
  import uart_frame_pkg::*;
#(
  parameter int          NUM_BYTES  = 4,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          word_valid,
  input  logic [8*NUM_BYTES-1:0]        word_data,
  output logic                          word_ready,
  output logic                          axiov,
  output logic [7:0]                    axiod,
  input  logic                          axioready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int WORD_W = 8 * NUM_BYTES;
  localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  state_t              state;
  state_t              ret_state;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          csum;
  logic [WORD_W-1:0]   frame_reg;
  logic [WORD_W-1:0]   head;
  logic [7:0]          gap_byte;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                xfer;
`ifdef UART_PACKETIZER_SEQ_EN
  logic [7:0]          seq;
`endif

  function automatic logic [7:0] pick_byte(input logic [WORD_W-1:0] w,
                                           input logic [IDX_W-1:0]  i);
    return w[8*i +: 8];
  endfunction

  // No pass-through: a full FIFO refuses even when the head is popped this cycle.
  assign word_ready = rst_n && !full;
  assign push       = word_valid && word_ready;
  assign pop        = (state == IDLE) && !empty;
  assign xfer       = axiov && axioready;
  assign busy       = (state != IDLE) || (fifo_count != '0);

  word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (word_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (pop) frame_reg <= head;
  end

  // Byte presented when the gap ends; idx and csum were already updated at the transfer.
  always_comb begin
    gap_byte = 8'h00;
    case (ret_state)
`ifdef UART_PACKETIZER_SEQ_EN
      SEQ:     gap_byte = seq;
`endif
      DATA:    gap_byte = pick_byte(frame_reg, idx);
      CSUM:    gap_byte = csum;
      default: gap_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ret_state <= IDLE;
      idx       <= '0;
      csum      <= 8'h00;
      axiov     <= 1'b0;
      axiod     <= 8'h00;
`ifdef UART_PACKETIZER_SEQ_EN
      seq       <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            csum  <= 8'h00;
            axiov <= 1'b1;
            axiod <= SYNC_BYTE;
            state <= SYNC;
          end
        end
        SYNC: begin
          if (xfer) begin
            axiov <= 1'b0;
            idx   <= IDX_W'(NUM_BYTES - 1);
            state <= GAP;
`ifdef UART_PACKETIZER_SEQ_EN
            ret_state <= SEQ;
`else
            ret_state <= DATA;
`endif
          end
        end
`ifdef UART_PACKETIZER_SEQ_EN
        SEQ: begin
          if (xfer) begin
            axiov     <= 1'b0;
            csum      <= csum + axiod;
            state     <= GAP;
            ret_state <= DATA;
          end
        end
`endif
        DATA: begin
          if (xfer) begin
            axiov <= 1'b0;
            csum  <= csum + axiod;
            state <= GAP;
            if (idx == '0) begin
              ret_state <= CSUM;
            end else begin
              ret_state <= DATA;
              idx       <= idx - 1'b1;
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            axiov     <= 1'b0;
            state     <= GAP;
            ret_state <= IDLE;
`ifdef UART_PACKETIZER_SEQ_EN
            seq       <= seq + 8'h01;
`endif
          end
        end
        GAP: begin
          state <= ret_state;
          if (ret_state != IDLE) begin
            axiov <= 1'b1;
            axiod <= gap_byte;
          end
        end
        default: begin
          state <= IDLE;
          axiov <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packetizer.sv
// Self-checking bench for uart_packetizer with a queue-based frame model.
// Honours UART_PACKETIZER_SEQ_EN the same way as the design.
module tb_uart_packetizer;

  localparam int NB  = 4;
  localparam int FD  = 4;
`ifdef UART_PACKETIZER_SEQ_EN
  localparam int HDR = 2;
`else
  localparam int HDR = 1;
`endif

  logic          clk;
  logic          rst_n;
  logic          word_valid;
  logic [31:0]   word_data;
  logic          word_ready;
  logic          axiov;
  logic [7:0]    axiod;
  logic          axioready;
  logic [2:0]    fifo_count;
  logic          busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         exp_seq = 0;

  logic       prev_xfer = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = 8'h00;
  logic       rand_done;

  uart_packetizer #(
    .NUM_BYTES  (NB),
    .FIFO_DEPTH (FD),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_ready (word_ready),
    .axiov      (axiov),
    .axiod      (axiod),
    .axioready  (axioready),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mid-cycle monitor: records accepted bytes and checks the gap and hold rules.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_xfer  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_xfer) begin
        tests++;
        if (axiov !== 1'b0) begin
          fails++;
          $display("FAIL gap_after_xfer: axiov=%b required 0", axiov);
        end
      end
      if (prev_stall) begin
        tests++;
        if (axiov !== 1'b1 || axiod !== prev_d) begin
          fails++;
          $display("FAIL hold_stable: axiov=%b axiod=%h required 1/%h", axiov, axiod, prev_d);
        end
      end
      prev_xfer  = axiov && axioready;
      prev_stall = axiov && !axioready;
      prev_d     = axiod;
      if (prev_xfer) rx_q.push_back(axiod);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    rx_q.delete();
    exp_q.delete();
    exp_seq = 0;
  endtask

  // Reference frame: sync, optional sequence number, bytes MSB first, sum mod 256.
  task automatic model_frame(input logic [31:0] w);
    int sum;
    logic [7:0] b;
    sum = 0;
    exp_q.push_back(8'hA5);
`ifdef UART_PACKETIZER_SEQ_EN
    exp_q.push_back(8'(exp_seq));
    sum = sum + exp_seq;
    exp_seq = (exp_seq + 1) % 256;
`endif
    for (int i = NB - 1; i >= 0; i--) begin
      b = w[8*i +: 8];
      exp_q.push_back(b);
      sum = sum + int'(b);
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  task automatic push_word(input logic [31:0] w);
    int n;
    n = 0;
    word_valid = 1'b1;
    word_data  = w;
    while (!word_ready && n < 500) begin
      tick();
      n++;
    end
    if (!word_ready) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: word_ready=%b required 1", word_ready);
    end else begin
      tick();
    end
    word_valid = 1'b0;
  endtask

  task automatic wait_rx(input int k);
    int n;
    n = 0;
    while (rx_q.size() < k && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic check_stream(input string name);
    int n;
    wait_rx(exp_q.size());
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_busy_idle: busy=%b required 0", name, busy);
    end
    tests++;
    if (rx_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s_length: got %0d bytes required %0d", name, rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      tests++;
      if (rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL %s_byte%0d: got %h required %h", name, i, rx_q[i], exp_q[i]);
      end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    word_valid = 1'b0;
    word_data = '0;
    axioready = 1'b0;
    repeat (3) tick();
    tests++;
    if (axiov !== 1'b0 || axiod !== 8'h00) begin
      fails++;
      $display("FAIL reset_out: axiov=%b axiod=%h required 0/00", axiov, axiod);
    end
    tests++;
    if (word_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready: word_ready=%b required 0", word_ready);
    end
    tests++;
    if (fifo_count !== 3'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_count: fifo_count=%0d busy=%b required 0/0", fifo_count, busy);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (word_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: word_ready=%b required 1", word_ready);
    end
  endtask

  task automatic test_single();
    axioready = 1'b1;
    word_valid = 1'b1;
    word_data = 32'h01020304;
    tick();
    word_valid = 1'b0;
    tests++;
    if (axiov !== 1'b0 || fifo_count !== 3'd1) begin
      fails++;
      $display("FAIL latency_push: axiov=%b fifo_count=%0d required 0/1", axiov, fifo_count);
    end
    tick();
    tests++;
    if (axiov !== 1'b1 || axiod !== 8'hA5 || fifo_count !== 3'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL latency_pop: axiov=%b axiod=%h cnt=%0d busy=%b required 1/a5/0/1",
               axiov, axiod, fifo_count, busy);
    end
`ifdef UART_PACKETIZER_SEQ_EN
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
`else
    exp_q = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
`endif
    exp_seq = exp_seq + 1;
    check_stream("single");
  endtask

  task automatic test_overflow();
    axioready = 1'b1;
    push_word(32'hFFFFFFFF);
`ifdef UART_PACKETIZER_SEQ_EN
    exp_q = '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD};
`else
    exp_q = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC};
`endif
    exp_seq = exp_seq + 1;
    check_stream("csum_overflow");
  endtask

  task automatic test_backpressure();
    axioready = 1'b1;
    push_word(32'h01020304);
    model_frame(32'h01020304);
    wait_rx(HDR + 1);
    axioready = 1'b0;
    repeat (11) tick();
    tests++;
    if (axiov !== 1'b1 || axiod !== 8'h02) begin
      fails++;
      $display("FAIL backpressure_hold: axiov=%b axiod=%h required 1/02", axiov, axiod);
    end
    axioready = 1'b1;
    check_stream("backpressure");
  endtask

  task automatic test_full();
    logic [31:0] w [6];
    logic        acc [6];
    axioready = 1'b0;
    for (int i = 0; i < 6; i++) w[i] = $urandom;
    for (int i = 0; i < 6; i++) begin
      word_valid = 1'b1;
      word_data  = w[i];
      acc[i] = word_ready;
      if (word_ready) model_frame(w[i]);
      tick();
    end
    word_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (acc[i] !== (i < 5)) begin
        fails++;
        $display("FAIL full_accept%0d: word_ready=%b required %b", i, acc[i], (i < 5));
      end
    end
    tests++;
    if (fifo_count !== 3'd4 || word_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_count: fifo_count=%0d word_ready=%b required 4/0", fifo_count, word_ready);
    end
    axioready = 1'b1;
    check_stream("full_fifo");
  endtask

  task automatic test_random();
    rand_done = 1'b0;
    fork
      begin
        logic [31:0] w;
        for (int i = 0; i < 12; i++) begin
          w = $urandom;
          push_word(w);
          model_frame(w);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          axioready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    axioready = 1'b1;
    check_stream("random");
  endtask

  task automatic test_reset_mid();
    axioready = 1'b0;
    push_word(32'h01020304);
    push_word(32'h55667788);
    axioready = 1'b1;
    wait_rx(HDR + 2);
    rst_n = 1'b0;
    #1;
    tests++;
    if (axiov !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0 || word_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: axiov=%b cnt=%0d busy=%b ready=%b required 0/0/0/0",
               axiov, fifo_count, busy, word_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    clear_model();
    tick();
    push_word(32'h11223344);
`ifdef UART_PACKETIZER_SEQ_EN
    exp_q = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
`else
    exp_q = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
`endif
    exp_seq = 1;
    check_stream("after_reset");
  endtask

`ifdef UART_PACKETIZER_SEQ_EN
  task automatic test_seq_wrap();
    logic [7:0] want;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_model();
    tick();
    axioready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      push_word(32'h01020304);
      model_frame(32'h01020304);
      wait_rx(uart_frame_pkg::frame_len(NB));
      if (i == 0 || i == 1 || i == 256) begin
        want = (i == 1) ? 8'h01 : 8'h00;
        tests++;
        if (rx_q.size() < 2 || rx_q[1] !== want) begin
          fails++;
          $display("FAIL seq_frame%0d: seq=%h required %h", i,
                   (rx_q.size() < 2) ? 8'hxx : rx_q[1], want);
        end
      end
      check_stream("seq");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_backpressure();
    test_full();
    test_random();
    test_reset_mid();
`ifdef UART_PACKETIZER_SEQ_EN
    test_seq_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
